// File: rtl/dsp_nco_sweep_ctrl.sv
// dsp_nco_sweep_ctrl: steps an NCO phase increment through a linear frequency
// sweep. It holds each hop for a programmable dwell and flags the NCO output
// samples with sample_valid, which trails nco_en by NCO_LAT cycles.
// Optional build macro: DSP_NCO_SWEEP_LOOP_EN. When it is defined, the sweep
// restarts from phi_start without a gap after the last hop. It then runs until
// abort or rst.
module dsp_nco_sweep_ctrl #(
    parameter int PHI_WIDTH = 32,
    parameter int CNT_WIDTH = 16,
    parameter int NCO_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PHI_WIDTH-1:0] cfg_phi_start,
    input  logic [PHI_WIDTH-1:0] cfg_phi_step,
    input  logic [CNT_WIDTH-1:0] cfg_steps,
    input  logic [CNT_WIDTH-1:0] cfg_dwell,
    output logic                 nco_en,
    output logic [PHI_WIDTH-1:0] nco_phi_inc,
    output logic                 nco_dither_en,
    output logic                 sample_valid,
    output logic [CNT_WIDTH-1:0] hop_idx,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

    state_t               state, state_n;
    logic [PHI_WIDTH-1:0] phi_step_r, phi_n;
`ifdef DSP_NCO_SWEEP_LOOP_EN
    logic [PHI_WIDTH-1:0] phi_start_r;
`endif
    logic [CNT_WIDTH-1:0] steps_m1_r, dwell_m1_r, dwell_cnt;
    logic [CNT_WIDTH-1:0] dcnt_n, hop_n, cfg_dwell_m1;
    logic                 en_n, done_n, cap, pipe_clr;

    // Zero dwell means one cycle. Store the value minus one so that the counter
    // ends at zero.
    assign cfg_dwell_m1 = (cfg_dwell == '0) ? '0 : cfg_dwell - CNT_WIDTH'(1);

    // Next-state and next-output logic. All outputs are registered below.
    always_comb begin
        state_n  = state;
        phi_n    = nco_phi_inc;
        en_n     = nco_en;
        hop_n    = hop_idx;
        dcnt_n   = dwell_cnt;
        done_n   = 1'b0;
        cap      = 1'b0;
        pipe_clr = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    cap     = 1'b1;
                    phi_n   = cfg_phi_start;
                    en_n    = 1'b1;
                    hop_n   = '0;
                    dcnt_n  = cfg_dwell_m1;
                    state_n = DWELL;
                end
            end
            DWELL: begin
                if (abort) begin
                    en_n     = 1'b0;
                    pipe_clr = 1'b1;
                    state_n  = IDLE;
                end else if (dwell_cnt != '0) begin
                    dcnt_n = dwell_cnt - CNT_WIDTH'(1);
                end else if (hop_idx < steps_m1_r) begin
                    phi_n  = nco_phi_inc + phi_step_r;
                    hop_n  = hop_idx + CNT_WIDTH'(1);
                    dcnt_n = dwell_m1_r;
                end else begin
`ifdef DSP_NCO_SWEEP_LOOP_EN
                    // Wrap back to the first hop with no gap in nco_en.
                    phi_n  = phi_start_r;
                    hop_n  = '0;
                    dcnt_n = dwell_m1_r;
                    done_n = 1'b1;
`else
                    en_n    = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
`endif
                end
            end
            DONE: begin
                pipe_clr = abort;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, output and captured-configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            nco_en        <= 1'b0;
            nco_dither_en <= 1'b0;
            nco_phi_inc   <= '0;
            hop_idx       <= '0;
            dwell_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            phi_step_r    <= '0;
            steps_m1_r    <= '0;
            dwell_m1_r    <= '0;
`ifdef DSP_NCO_SWEEP_LOOP_EN
            phi_start_r   <= '0;
`endif
        end else begin
            state         <= state_n;
            nco_en        <= en_n;
            nco_dither_en <= en_n;
            nco_phi_inc   <= phi_n;
            hop_idx       <= hop_n;
            dwell_cnt     <= dcnt_n;
            busy          <= (state_n != IDLE);
            done          <= done_n;
            if (cap) begin
                phi_step_r <= cfg_phi_step;
                steps_m1_r <= (cfg_steps == '0) ? '0 : cfg_steps - CNT_WIDTH'(1);
                dwell_m1_r <= cfg_dwell_m1;
`ifdef DSP_NCO_SWEEP_LOOP_EN
                phi_start_r <= cfg_phi_start;
`endif
            end
        end
    end

    generate
        if (NCO_LAT > 0) begin : g_lat
            logic [NCO_LAT-1:0] vld_pipe;
            // Delay line that matches the NCO latency. An abort flushes it so
            // that stale samples are not flagged.
            always_ff @(posedge clk) begin
                if (rst || pipe_clr) vld_pipe <= '0;
                else                 vld_pipe <= (vld_pipe << 1) | NCO_LAT'(nco_en);
            end
            assign sample_valid = vld_pipe[NCO_LAT-1];
        end else begin : g_nolat
            assign sample_valid = nco_en;
        end
    endgenerate

endmodule
